// File: rtl/mam_mem_arbiter_if.sv
// Bus bundle for mam_mem_arbiter: N requester channels plus the shared memory port.
// slave is the arbiter's view; master is the requesters plus the memory.
interface mam_mem_arbiter_if #(
  parameter int N          = 2,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 32
);
  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  logic [N-1:0]              req_valid;
  logic [N-1:0]              req_ready;
  logic [N-1:0]              req_rw;
  logic [N*ADDR_WIDTH-1:0]   req_addr;
  logic [N-1:0]              req_burst;
  logic [N*14-1:0]           req_beats;
  logic [N-1:0]              write_valid;
  logic [N*DATA_WIDTH-1:0]   write_data;
  logic [N*STRB_WIDTH-1:0]   write_strb;
  logic [N-1:0]              write_ready;
  logic [N-1:0]              read_valid;
  logic [N*DATA_WIDTH-1:0]   read_data;
  logic [N-1:0]              read_ready;

  logic                      mem_req_valid;
  logic                      mem_req_ready;
  logic                      mem_req_rw;
  logic [ADDR_WIDTH-1:0]     mem_req_addr;
  logic                      mem_req_burst;
  logic [13:0]               mem_req_beats;
  logic                      mem_write_valid;
  logic [DATA_WIDTH-1:0]     mem_write_data;
  logic [STRB_WIDTH-1:0]     mem_write_strb;
  logic                      mem_write_ready;
  logic                      mem_read_valid;
  logic [DATA_WIDTH-1:0]     mem_read_data;
  logic                      mem_read_ready;

  modport slave (
    input  req_valid, req_rw, req_addr, req_burst, req_beats,
           write_valid, write_data, write_strb, read_ready,
           mem_req_ready, mem_write_ready, mem_read_valid, mem_read_data,
    output req_ready, write_ready, read_valid, read_data,
           mem_req_valid, mem_req_rw, mem_req_addr, mem_req_burst, mem_req_beats,
           mem_write_valid, mem_write_data, mem_write_strb, mem_read_ready
  );

  modport master (
    output req_valid, req_rw, req_addr, req_burst, req_beats,
           write_valid, write_data, write_strb, read_ready,
           mem_req_ready, mem_write_ready, mem_read_valid, mem_read_data,
    input  req_ready, write_ready, read_valid, read_data,
           mem_req_valid, mem_req_rw, mem_req_addr, mem_req_burst, mem_req_beats,
           mem_write_valid, mem_write_data, mem_write_strb, mem_read_ready
  );
endinterface

// File: rtl/mam_mem_arbiter.sv
// Round-robin, transaction-granular arbiter sharing one osd_mam memory port among N requesters.
// Optional MAM_ARB_LOCK_EN adds req_lock, which keeps the grant across back-to-back transactions.
module mam_mem_arbiter #(
  parameter int N          = 2,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
`ifdef MAM_ARB_LOCK_EN
  input  logic [N-1:0]         req_lock,
`endif
  mam_mem_arbiter_if.slave     bus,
  output logic [N-1:0]         grant
);
  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam int SW = DATA_WIDTH / 8;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_REQ   = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_READ  = 2'd3;

  logic [1:0]    r_state;
  logic [N-1:0]  r_grant;
  logic [PW-1:0] r_gidx;
  logic [PW-1:0] r_ptr;
  logic [13:0]   r_cnt;

  logic          w_found_hi, w_found_any;
  logic [PW-1:0] w_idx_hi, w_idx_any, w_pick_idx, w_next_ptr;

  // Lowest requester at or above the pointer wins; otherwise wrap to the lowest overall.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    w_found_hi  = 1'b0;
    w_found_any = 1'b0;
    w_idx_hi    = '0;
    w_idx_any   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (bus.req_valid[i]) begin
        w_found_any = 1'b1;
        w_idx_any   = PW'(i);
        if (i >= int'(r_ptr)) begin
          w_found_hi = 1'b1;
          w_idx_hi   = PW'(i);
        end
      end
    end
    w_pick_idx = w_found_hi ? w_idx_hi : w_idx_any;
  end

  logic                  w_sel_valid, w_sel_rw, w_sel_burst, w_sel_wvalid, w_sel_rready;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic [13:0]           w_sel_beats;
  logic [DATA_WIDTH-1:0] w_sel_wdata;
  logic [SW-1:0]         w_sel_wstrb;

  always_comb begin
    w_sel_valid  = 1'b0;
    w_sel_rw     = 1'b0;
    w_sel_burst  = 1'b0;
    w_sel_wvalid = 1'b0;
    w_sel_rready = 1'b0;
    w_sel_addr   = '0;
    w_sel_beats  = '0;
    w_sel_wdata  = '0;
    w_sel_wstrb  = '0;
    for (int i = 0; i < N; i++) begin
      if (r_grant[i]) begin
        w_sel_valid  = bus.req_valid[i];
        w_sel_rw     = bus.req_rw[i];
        w_sel_burst  = bus.req_burst[i];
        w_sel_wvalid = bus.write_valid[i];
        w_sel_rready = bus.read_ready[i];
        w_sel_addr   = bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        w_sel_beats  = bus.req_beats[i*14 +: 14];
        w_sel_wdata  = bus.write_data[i*DATA_WIDTH +: DATA_WIDTH];
        w_sel_wstrb  = bus.write_strb[i*SW +: SW];
      end
    end
  end

  logic w_hold;
`ifdef MAM_ARB_LOCK_EN
  assign w_hold = |(r_grant & req_lock);
`else
  assign w_hold = 1'b0;
`endif

  logic w_in_req, w_in_wr, w_in_rd, w_beat_hs;
  assign w_in_req = (r_state == S_REQ);
  assign w_in_wr  = (r_state == S_WRITE);
  assign w_in_rd  = (r_state == S_READ);

  // Every output is gated by state, so idle/reset drives all valids, readies and data to 0.
  assign bus.mem_req_valid   = w_in_req & w_sel_valid;
  assign bus.mem_req_rw      = w_in_req & w_sel_rw;
  assign bus.mem_req_addr    = w_in_req ? w_sel_addr : '0;
  assign bus.mem_req_burst   = w_in_req & w_sel_burst;
  assign bus.mem_req_beats   = w_in_req ? w_sel_beats : '0;
  assign bus.req_ready       = w_in_req ? (r_grant & {N{bus.mem_req_ready}}) : '0;

  assign bus.mem_write_valid = w_in_wr & w_sel_wvalid;
  assign bus.mem_write_data  = w_in_wr ? w_sel_wdata : '0;
  assign bus.mem_write_strb  = w_in_wr ? w_sel_wstrb : '0;
  assign bus.write_ready     = w_in_wr ? (r_grant & {N{bus.mem_write_ready}}) : '0;

  assign bus.read_valid      = w_in_rd ? (r_grant & {N{bus.mem_read_valid}}) : '0;
  assign bus.read_data       = w_in_rd ? {N{bus.mem_read_data}} : '0;
  assign bus.mem_read_ready  = w_in_rd & w_sel_rready;

  assign grant = r_grant;

  assign w_beat_hs  = (w_in_wr & bus.mem_write_valid & bus.mem_write_ready) |
                      (w_in_rd & bus.mem_read_valid & bus.mem_read_ready);
  assign w_next_ptr = (r_gidx == PW'(N - 1)) ? '0 : r_gidx + PW'(1);

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      r_state <= S_IDLE;
      r_grant <= '0;
      r_gidx  <= '0;
      r_ptr   <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found_any) begin
            r_grant <= N'(1) << w_pick_idx;
            r_gidx  <= w_pick_idx;
            r_state <= S_REQ;
          end
        end
        S_REQ: begin
          if (!w_sel_valid) begin
            r_state <= S_IDLE;
            r_grant <= '0;
          end else if (bus.mem_req_ready) begin
            r_cnt   <= (w_sel_burst && (w_sel_beats != '0)) ? w_sel_beats : 14'd1;
            r_state <= w_sel_rw ? S_WRITE : S_READ;
          end
        end
        default: begin
          if (w_beat_hs) begin
            r_cnt <= r_cnt - 14'd1;
            if (r_cnt == 14'd1) begin
              if (w_hold) begin
                r_state <= S_REQ;
              end else begin
                r_state <= S_IDLE;
                r_grant <= '0;
                r_ptr   <= w_next_ptr;
              end
            end
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mam_mem_arbiter.sv
// Directed bench for mam_mem_arbiter: transaction table plus hand-written multi-cycle sequences.
// Define MAM_ARB_LOCK_EN for both bench and RTL to exercise the lock sequence.
module tb_mam_mem_arbiter;
  localparam int N  = 2;
  localparam int DW = 16;
  localparam int AW = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] grant;
`ifdef MAM_ARB_LOCK_EN
  logic [N-1:0] req_lock;
`endif
  int n_checks = 0;
  int n_fail   = 0;

  mam_mem_arbiter_if #(.N(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus();

  mam_mem_arbiter #(.N(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk      (clk),
    .rst      (rst),
`ifdef MAM_ARB_LOCK_EN
    .req_lock (req_lock),
`endif
    .bus      (bus),
    .grant    (grant)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          r;
    logic        rw;
    logic [31:0] addr;
    logic        burst;
    logic [13:0] beats;
    logic [15:0] base;
    logic [1:0]  strb;
    int          exp_beats;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic clear_inputs();
    bus.req_valid       = '0;
    bus.req_rw          = '0;
    bus.req_addr        = '0;
    bus.req_burst       = '0;
    bus.req_beats       = '0;
    bus.write_valid     = '0;
    bus.write_data      = '0;
    bus.write_strb      = '0;
    bus.read_ready      = '0;
    bus.mem_req_ready   = 1'b0;
    bus.mem_write_ready = 1'b0;
    bus.mem_read_valid  = 1'b0;
    bus.mem_read_data   = '0;
`ifdef MAM_ARB_LOCK_EN
    req_lock            = '0;
`endif
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    cyc();
    cyc();
    rst = 1'b0;
  endtask

  task automatic set_req(input int r, input logic v, input logic rw, input logic [31:0] addr,
                         input logic burst, input logic [13:0] beats);
    bus.req_valid[r]          = v;
    bus.req_rw[r]             = rw;
    bus.req_addr[r*AW +: AW]  = addr;
    bus.req_burst[r]          = burst;
    bus.req_beats[r*14 +: 14] = beats;
  endtask

  // Bounded wait for the arbiter to grant; an expired bound shows up as a grant mismatch.
  task automatic wait_grant(input logic [1:0] exp, input string name);
    int n = 0;
    while (grant == '0 && n < 10) begin
      cyc();
      n++;
    end
    check(name, 64'(grant), 64'(exp));
  endtask

  task automatic run_txn(input vec_t v, input int t);
    logic [1:0] g;
    g = 2'(1 << v.r);
    set_req(v.r, 1'b1, v.rw, v.addr, v.burst, v.beats);
    bus.mem_req_ready = 1'b1;
    settle();
    wait_grant(g, $sformatf("t%0d_grant", t));
    check($sformatf("t%0d_req_valid", t), 64'(bus.mem_req_valid), 64'(1));
    check($sformatf("t%0d_req_rw", t), 64'(bus.mem_req_rw), 64'(v.rw));
    check($sformatf("t%0d_req_addr", t), 64'(bus.mem_req_addr), 64'(v.addr));
    check($sformatf("t%0d_req_burst", t), 64'(bus.mem_req_burst), 64'(v.burst));
    check($sformatf("t%0d_req_beats", t), 64'(bus.mem_req_beats), 64'(v.beats));
    check($sformatf("t%0d_req_ready", t), 64'(bus.req_ready), 64'(g));
    cyc();
    bus.req_valid[v.r] = 1'b0;
    bus.mem_req_ready  = 1'b0;
    for (int k = 0; k < v.exp_beats; k++) begin
      if (v.rw) begin
        bus.write_valid[v.r]          = 1'b1;
        bus.write_data[v.r*DW +: DW]  = v.base + 16'(k);
        bus.write_strb[v.r*2 +: 2]    = v.strb;
        bus.mem_write_ready           = 1'b1;
        settle();
        check($sformatf("t%0d_b%0d_wvalid", t, k), 64'(bus.mem_write_valid), 64'(1));
        check($sformatf("t%0d_b%0d_wdata", t, k), 64'(bus.mem_write_data), 64'(v.base + 16'(k)));
        check($sformatf("t%0d_b%0d_wstrb", t, k), 64'(bus.mem_write_strb), 64'(v.strb));
        check($sformatf("t%0d_b%0d_wready", t, k), 64'(bus.write_ready), 64'(g));
      end else begin
        bus.mem_read_valid   = 1'b1;
        bus.mem_read_data    = v.base + 16'(k);
        bus.read_ready[v.r]  = 1'b1;
        settle();
        check($sformatf("t%0d_b%0d_rvalid", t, k), 64'(bus.read_valid), 64'(g));
        check($sformatf("t%0d_b%0d_rdata", t, k), 64'(bus.read_data[v.r*DW +: DW]), 64'(v.base + 16'(k)));
        check($sformatf("t%0d_b%0d_rready", t, k), 64'(bus.mem_read_ready), 64'(1));
      end
      cyc();
    end
    clear_inputs();
    settle();
    check($sformatf("t%0d_released", t), 64'(grant), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] rr_exp [4];
    int k, n, stall;
    logic tog, rr;

    // Reset with busy inputs: every output must still read 0.
    rst = 1'b1;
    clear_inputs();
    bus.req_valid       = 2'b11;
    bus.write_valid     = 2'b11;
    bus.write_data      = '1;
    bus.read_ready      = 2'b11;
    bus.mem_req_ready   = 1'b1;
    bus.mem_write_ready = 1'b1;
    bus.mem_read_valid  = 1'b1;
    bus.mem_read_data   = '1;
    cyc();
    cyc();
    settle();
    check("rst_grant", 64'(grant), 64'(0));
    check("rst_req_ready", 64'(bus.req_ready), 64'(0));
    check("rst_write_ready", 64'(bus.write_ready), 64'(0));
    check("rst_read_valid", 64'(bus.read_valid), 64'(0));
    check("rst_read_data", 64'(bus.read_data), 64'(0));
    check("rst_mem_req_valid", 64'(bus.mem_req_valid), 64'(0));
    check("rst_mem_req_addr", 64'(bus.mem_req_addr), 64'(0));
    check("rst_mem_write_valid", 64'(bus.mem_write_valid), 64'(0));
    check("rst_mem_write_data", 64'(bus.mem_write_data), 64'(0));
    check("rst_mem_read_ready", 64'(bus.mem_read_ready), 64'(0));
    clear_inputs();
    rst = 1'b0;

    vecs[0] = '{r: 0, rw: 1'b1, addr: 32'h0000_0000, burst: 1'b0, beats: 14'd0, base: 16'h000F, strb: 2'b11, exp_beats: 1};
    vecs[1] = '{r: 1, rw: 1'b0, addr: 32'h0000_1000, burst: 1'b1, beats: 14'd3, base: 16'hA000, strb: 2'b00, exp_beats: 3};
    vecs[2] = '{r: 0, rw: 1'b1, addr: 32'hDEAD_BEE0, burst: 1'b1, beats: 14'd0, base: 16'h5555, strb: 2'b01, exp_beats: 1};
    vecs[3] = '{r: 1, rw: 1'b1, addr: 32'h0000_0008, burst: 1'b0, beats: 14'd5, base: 16'h1234, strb: 2'b10, exp_beats: 1};
    vecs[4] = '{r: 0, rw: 1'b0, addr: 32'hFFFF_FFFC, burst: 1'b0, beats: 14'd0, base: 16'hBEEF, strb: 2'b00, exp_beats: 1};
    for (int t = 0; t < 5; t++) run_txn(vecs[t], t);

    // Round-robin: both requesters keep reading; grants must alternate from requester 0.
    do_reset();
    rr_exp = '{2'b01, 2'b10, 2'b01, 2'b10};
    set_req(0, 1'b1, 1'b0, 32'h10, 1'b0, 14'd0);
    set_req(1, 1'b1, 1'b0, 32'h20, 1'b0, 14'd0);
    bus.mem_req_ready  = 1'b1;
    bus.mem_read_valid = 1'b1;
    bus.mem_read_data  = 16'h00AA;
    bus.read_ready     = 2'b11;
    for (int t = 0; t < 4; t++) begin
      wait_grant(rr_exp[t], $sformatf("rr%0d_grant", t));
      cyc();
      check($sformatf("rr%0d_read_valid", t), 64'(bus.read_valid), 64'(rr_exp[t]));
      cyc();
      check($sformatf("rr%0d_gap", t), 64'(grant), 64'(0));
    end

    // Six-beat write burst from requester 1 with a toggling mem_write_ready; requester 0 waits.
    do_reset();
    set_req(1, 1'b1, 1'b1, 32'h40, 1'b1, 14'd6);
    bus.mem_req_ready = 1'b1;
    settle();
    wait_grant(2'b10, "b_grant");
    cyc();
    bus.req_valid[1]  = 1'b0;
    bus.mem_req_ready = 1'b0;
    set_req(0, 1'b1, 1'b0, 32'h50, 1'b0, 14'd0);
    k = 0; n = 0; tog = 1'b0;
    while (k < 6 && n < 40) begin
      bus.write_valid[1]     = 1'b1;
      bus.write_data[31:16]  = 16'(k + 1);
      bus.mem_write_ready    = tog;
      settle();
      check($sformatf("b_n%0d_grant", n), 64'(grant), 64'(2'b10));
      check($sformatf("b_n%0d_wdata", n), 64'(bus.mem_write_data), 64'(k + 1));
      check($sformatf("b_n%0d_req0_ready", n), 64'(bus.req_ready), 64'(0));
      if (tog) k++;
      tog = ~tog;
      n++;
      cyc();
    end
    bus.write_valid     = '0;
    bus.mem_write_ready = 1'b0;
    settle();
    check("b_idle_gap", 64'(grant), 64'(0));
    cyc();
    check("b_req0_after", 64'(grant), 64'(2'b01));
    check("b_req0_addr", 64'(bus.mem_req_addr), 64'(32'h50));

    // Four-beat read burst to requester 0 with read_ready low for 3 cycles on beat 2.
    do_reset();
    set_req(0, 1'b1, 1'b0, 32'h80, 1'b1, 14'd4);
    bus.mem_req_ready = 1'b1;
    settle();
    wait_grant(2'b01, "r_grant");
    cyc();
    bus.req_valid[0]   = 1'b0;
    bus.mem_req_ready  = 1'b0;
    bus.mem_read_valid = 1'b1;
    bus.read_ready[1]  = 1'b1;
    k = 0; n = 0; stall = 0;
    while (k < 4 && n < 30) begin
      rr = !(k == 1 && stall < 3);
      bus.mem_read_data = 16'h0100 + 16'(k);
      bus.read_ready[0] = rr;
      settle();
      check($sformatf("r_n%0d_grant", n), 64'(grant), 64'(2'b01));
      check($sformatf("r_n%0d_mem_rready", n), 64'(bus.mem_read_ready), 64'(rr));
      check($sformatf("r_n%0d_rvalid", n), 64'(bus.read_valid), 64'(2'b01));
      check($sformatf("r_n%0d_rdata", n), 64'(bus.read_data[15:0]), 64'(16'h0100 + 16'(k)));
      if (rr) k++; else stall++;
      n++;
      cyc();
    end
    bus.mem_read_valid = 1'b0;
    settle();
    check("r_released", 64'(grant), 64'(0));

    // Reset during beat 3 of an eight-beat write, then a fresh request from requester 1.
    do_reset();
    set_req(1, 1'b1, 1'b1, 32'h100, 1'b1, 14'd8);
    bus.mem_req_ready = 1'b1;
    settle();
    wait_grant(2'b10, "m_grant");
    cyc();
    bus.req_valid[1]    = 1'b0;
    bus.mem_req_ready   = 1'b0;
    bus.write_valid[1]  = 1'b1;
    bus.mem_write_ready = 1'b1;
    for (int b = 0; b < 2; b++) begin
      bus.write_data[31:16] = 16'(b + 1);
      settle();
      check($sformatf("m_b%0d_wvalid", b), 64'(bus.mem_write_valid), 64'(1));
      cyc();
    end
    bus.write_data[31:16] = 16'd3;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    settle();
    check("m_rst_grant", 64'(grant), 64'(0));
    check("m_rst_wvalid", 64'(bus.mem_write_valid), 64'(0));
    check("m_rst_wdata", 64'(bus.mem_write_data), 64'(0));
    check("m_rst_wready", 64'(bus.write_ready), 64'(0));
    check("m_rst_req_valid", 64'(bus.mem_req_valid), 64'(0));
    set_req(1, 1'b1, 1'b1, 32'h200, 1'b0, 14'd0);
    settle();
    wait_grant(2'b10, "m_fresh_grant");
    check("m_fresh_addr", 64'(bus.mem_req_addr), 64'(32'h200));

    // Requester drops req_valid in REQ: no memory request, pointer stays at 0.
    do_reset();
    set_req(0, 1'b1, 1'b0, 32'h600, 1'b0, 14'd0);
    settle();
    wait_grant(2'b01, "d_grant");
    bus.req_valid[0] = 1'b0;
    settle();
    check("d_no_mem_req", 64'(bus.mem_req_valid), 64'(0));
    cyc();
    check("d_released", 64'(grant), 64'(0));
    set_req(0, 1'b1, 1'b0, 32'h600, 1'b0, 14'd0);
    set_req(1, 1'b1, 1'b0, 32'h700, 1'b0, 14'd0);
    settle();
    wait_grant(2'b01, "d_ptr_kept");

`ifdef MAM_ARB_LOCK_EN
    // Requester 0 locks across two single writes while requester 1 waits.
    do_reset();
    set_req(0, 1'b1, 1'b1, 32'h300, 1'b0, 14'd0);
    set_req(1, 1'b1, 1'b0, 32'h400, 1'b0, 14'd0);
    req_lock            = 2'b01;
    bus.mem_req_ready   = 1'b1;
    bus.write_valid[0]  = 1'b1;
    bus.write_data[15:0] = 16'h000A;
    bus.mem_write_ready = 1'b1;
    settle();
    wait_grant(2'b01, "l_grant");
    cyc();
    check("l_w1_valid", 64'(bus.mem_write_valid), 64'(1));
    cyc();
    check("l_kept_grant", 64'(grant), 64'(2'b01));
    check("l_kept_req", 64'(bus.mem_req_valid), 64'(1));
    req_lock = 2'b00;
    set_req(0, 1'b1, 1'b1, 32'h304, 1'b0, 14'd0);
    settle();
    check("l_second_addr", 64'(bus.mem_req_addr), 64'(32'h304));
    cyc();
    bus.req_valid[0] = 1'b0;
    settle();
    check("l_w2_valid", 64'(bus.mem_write_valid), 64'(1));
    cyc();
    check("l_released", 64'(grant), 64'(0));
    wait_grant(2'b10, "l_req1_after");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/mam_mem_arbiter.md
Name: mam_mem_arbiter

Overview:
- Shares one memory request/data interface between N osd_mam-style requesters, e.g. debug MAM plus a second debug or DMA master.
- Sits between the requester req/write/read channels and the single memory-side port.
- Round-robin arbitration at transaction granularity.
- A granted transaction holds the memory port until all beats are transferred.

Parameters:
- N, 2, number of requesters (2..8)
- DATA_WIDTH, 16, data width of write and read beats
- ADDR_WIDTH, 32, address width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- req_valid  in  N  per-requester request valid
- req_ready  out  N  per-requester request accepted
- req_rw  in  N  1=write, 0=read
- req_addr  in  N*ADDR_WIDTH  flattened start addresses, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_burst  in  N  burst flag
- req_beats  in  N*14  burst beat counts
- write_valid  in  N  write beat valid
- write_data  in  N*DATA_WIDTH  write beats
- write_strb  in  N*DATA_WIDTH/8  byte strobes
- write_ready  out  N  write beat accepted
- read_valid  out  N  read beat valid
- read_data  out  N*DATA_WIDTH  read beats, broadcast to all requester slots
- read_ready  in  N  read beat accepted
- mem_req_valid/mem_req_ready/mem_req_rw/mem_req_addr/mem_req_burst/mem_req_beats  out/in/out/out/out/out  1/1/1/ADDR_WIDTH/1/14  memory request channel
- mem_write_valid/mem_write_data/mem_write_strb/mem_write_ready  out/out/out/in  1/DATA_WIDTH/DATA_WIDTH/8/1  memory write channel
- mem_read_valid/mem_read_data/mem_read_ready  in/in/out  1/DATA_WIDTH/1  memory read channel
- grant  out  N  one-hot current owner, 0 when idle

Behaviour:
- Reset:
  - state=IDLE, grant=0, rr pointer=0, beat counter=0.
  - All valid/ready outputs 0; data/addr outputs 0.
- IDLE:
  - Scan req_valid from pointer upward with wrap; first set bit wins.
  - Register it in grant and go to REQ. Arbitration costs 1 cycle.
  - No req_valid: stay in IDLE.
- REQ:
  - Mux the granted request onto mem_req_*, combinationally.
  - req_ready[g] = mem_req_ready. Other req_ready bits are 0.
  - On mem_req_valid & mem_req_ready, load the beat counter with req_burst ? req_beats : 1.
  - req_burst=1 with req_beats=0 loads 1.
  - Next state is WRITE if rw=1, else READ.
- WRITE:
  - mem_write_* = requester g's write channel; write_ready[g] = mem_write_ready.
  - The counter decrements on each handshake.
- READ:
  - read_valid[g] = mem_read_valid; mem_read_ready = read_ready[g].
  - The counter decrements on each handshake.
  - Non-granted read_valid bits are 0.
- Final beat handshake (counter==1):
  - Go to IDLE, grant=0, pointer = g+1 mod N.
  - Next arbitration happens in the following cycle, giving at least 1 idle cycle between transactions.
- Isolation:
  - Non-granted requesters see all ready bits 0.
  - Their valids are ignored and may stay asserted indefinitely.
- Stalls: the ready/valid handshakes on all channels follow the ready/valid rule and are never broken.
  - Stalls of any length on mem_req_ready, mem_write_ready or read_ready hold the state.
  - No timeout.
- A requester dropping req_valid while in REQ before the handshake: return to IDLE with no memory request issued; pointer unchanged.
- Reset mid-transaction: immediate return to the reset state. The memory side is expected to be reset by the same rst.

Optional Feature:
- MAM_ARB_LOCK_EN defined:
  - Adds input req_lock[N].
  - If req_lock[g]=1 at the final beat handshake, the grant is kept and the FSM enters REQ directly; the pointer does not rotate.
  - Used for MAM multi-packet bursts split across requests.
- Undefined: no req_lock port; grant is always released after every transaction.

Test Plan:
- Single write: req0 write single addr 0x0, data 0x000F -> mem_req_rw=1, addr 0x0, beats=1; exactly one mem_write beat 0x000F; grant 01 then 00.
- Round-robin: req0 and req1 both hold valid, read single each -> grant order 01,10,01,10; no requester served twice while the other waits.
- Burst write 6 beats, req1, data 0x0001..0x0006, mem_write_ready toggling every other cycle -> 6 beats in order; req0 request during the burst is not granted until the 6th beat completes.
- Read burst 4 beats to req0 with read_ready held low 3 cycles on beat 2 -> mem_read_ready low those 3 cycles; no beat lost or duplicated; read_valid[1] stays 0.
- Reset asserted during beat 3 of an 8-beat write -> next cycle all outputs 0, grant 0; a fresh req1 request after reset is granted normally.
- MAM_ARB_LOCK_EN: req0 lock=1 for two single writes while req1 is waiting -> both req0 transactions complete before req1 is granted.
